// File: rtl/ray_frame_scheduler.sv
// ray_frame_scheduler: walks a frame in raster order, running one tracer job per pixel
// and handing each hit/timeout/face result downstream over a valid/ready port.
module ray_frame_scheduler #(
  parameter int PX_BITS          = 6,
  parameter int PY_BITS          = 6,
  parameter int H_RES            = 40,
  parameter int V_RES            = 30,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int CNT_BITS         = 11
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [STEP_COUNT_WIDTH-1:0] cfg_max_steps,
  output logic                        busy,
  output logic                        frame_done,
  output logic [CNT_BITS-1:0]         hit_count,
  output logic                        setup_req,
  output logic [PX_BITS-1:0]          setup_px,
  output logic [PY_BITS-1:0]          setup_py,
  input  logic                        setup_ack,
  input  logic                        trace_ready,
  output logic                        job_loaded,
  output logic [STEP_COUNT_WIDTH-1:0] max_steps,
  input  logic                        trace_done,
  input  logic                        trace_hit,
  input  logic                        trace_timeout,
  input  logic [2:0]                  trace_face,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [PX_BITS-1:0]          res_px,
  output logic [PY_BITS-1:0]          res_py,
  output logic                        res_hit,
  output logic                        res_timeout,
  output logic [2:0]                  res_face
);
  localparam logic [PX_BITS-1:0] X_LAST = PX_BITS'(H_RES - 1);
  localparam logic [PY_BITS-1:0] Y_LAST = PY_BITS'(V_RES - 1);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, OUTPUT, DRAIN} state_t;
  state_t                        state_q, state_d;
  logic [PX_BITS-1:0]            px_q, px_d, res_px_q, res_px_d;
  logic [PY_BITS-1:0]            py_q, py_d, res_py_q, res_py_d;
  logic [STEP_COUNT_WIDTH-1:0]   max_steps_q, max_steps_d;
  logic [CNT_BITS-1:0]           hit_count_q, hit_count_d;
  logic                          frame_done_q, frame_done_d;
  logic                          res_hit_q, res_hit_d, res_timeout_q, res_timeout_d;
  logic [2:0]                    res_face_q, res_face_d;
  always_comb begin
    state_d       = state_q;
    px_d          = px_q;
    py_d          = py_q;
    max_steps_d   = max_steps_q;
    hit_count_d   = hit_count_q;
    frame_done_d  = 1'b0;
    res_px_d      = res_px_q;
    res_py_d      = res_py_q;
    res_hit_d     = res_hit_q;
    res_timeout_d = res_timeout_q;
    res_face_d    = res_face_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d     = SETUP;
        px_d        = '0;
        py_d        = '0;
        hit_count_d = '0;
        max_steps_d = cfg_max_steps;
      end
      SETUP: state_d = abort ? IDLE : (setup_ack ? ISSUE : SETUP);
      ISSUE: state_d = abort ? IDLE : (trace_ready ? WAIT : ISSUE);
      // a done coinciding with abort already retired the job, so there is nothing to drain
      WAIT: if (abort) state_d = trace_done ? IDLE : DRAIN;
      else if (trace_done) begin
        state_d       = OUTPUT;
        res_px_d      = px_q;
        res_py_d      = py_q;
        res_hit_d     = trace_hit;
        res_timeout_d = trace_timeout;
        res_face_d    = trace_face;
      end
      OUTPUT: if (abort) state_d = IDLE;
      else if (res_ready) begin
        hit_count_d = (res_hit_q && !(&hit_count_q)) ? hit_count_q + CNT_BITS'(1) : hit_count_q;
        if (px_q == X_LAST && py_q == Y_LAST) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          px_d    = (px_q == X_LAST) ? '0 : px_q + 1'b1;
          py_d    = (px_q == X_LAST) ? py_q + 1'b1 : py_q;
          state_d = SETUP;
        end
      end
      DRAIN: if (trace_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      px_q          <= '0;
      py_q          <= '0;
      max_steps_q   <= '0;
      hit_count_q   <= '0;
      frame_done_q  <= 1'b0;
      res_px_q      <= '0;
      res_py_q      <= '0;
      res_hit_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      res_face_q    <= '0;
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      py_q          <= py_d;
      max_steps_q   <= max_steps_d;
      hit_count_q   <= hit_count_d;
      frame_done_q  <= frame_done_d;
      res_px_q      <= res_px_d;
      res_py_q      <= res_py_d;
      res_hit_q     <= res_hit_d;
      res_timeout_q <= res_timeout_d;
      res_face_q    <= res_face_d;
    end
  end
  assign busy        = state_q != IDLE;
  assign setup_req   = state_q == SETUP;
  assign job_loaded  = (state_q == ISSUE) && trace_ready;
  assign res_valid   = state_q == OUTPUT;
  assign frame_done  = frame_done_q;
  assign hit_count   = hit_count_q;
  assign setup_px    = px_q;
  assign setup_py    = py_q;
  assign max_steps   = max_steps_q;
  assign res_px      = res_px_q;
  assign res_py      = res_py_q;
  assign res_hit     = res_hit_q;
  assign res_timeout = res_timeout_q;
  assign res_face    = res_face_q;
endmodule

// File: tb/tb_ray_frame_scheduler.sv
// tb_ray_frame_scheduler: table-driven and randomized frames on a 2x2 screen against a
// raster-order reference model, plus abort/start/reset corner sequences.
module tb_ray_frame_scheduler;
  localparam int H = 2, V = 2, PXB = 3, PYB = 3, SW = 8, CB = 3;
  logic clock = 0, reset_n = 1, start = 0, abort = 0;
  logic setup_ack = 0, trace_ready = 0, trace_done = 0, trace_hit = 0, trace_timeout = 0, res_ready = 0;
  logic [SW-1:0] cfg_max_steps = '0;
  logic [2:0] trace_face = '0;
  logic busy, frame_done, setup_req, job_loaded, res_valid, res_hit, res_timeout;
  logic [CB-1:0] hit_count;
  logic [PXB-1:0] setup_px, res_px;
  logic [PYB-1:0] setup_py, res_py;
  logic [SW-1:0] max_steps;
  logic [2:0] res_face;

  ray_frame_scheduler #(.PX_BITS(PXB), .PY_BITS(PYB), .H_RES(H), .V_RES(V),
    .STEP_COUNT_WIDTH(SW), .CNT_BITS(CB)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .cfg_max_steps(cfg_max_steps),
    .busy(busy), .frame_done(frame_done), .hit_count(hit_count), .setup_req(setup_req),
    .setup_px(setup_px), .setup_py(setup_py), .setup_ack(setup_ack), .trace_ready(trace_ready),
    .job_loaded(job_loaded), .max_steps(max_steps), .trace_done(trace_done), .trace_hit(trace_hit),
    .trace_timeout(trace_timeout), .trace_face(trace_face), .res_valid(res_valid), .res_ready(res_ready),
    .res_px(res_px), .res_py(res_py), .res_hit(res_hit), .res_timeout(res_timeout), .res_face(res_face));

  always #5 clock = ~clock;

  typedef struct { int ack_d; int rdy_d; int lat; int rr_d; logic hit; logic to; logic [2:0] face; } pix_t;
  typedef struct { pix_t p; int ex; int ey; } vec_t;

  int checks = 0, failures = 0, jl_cnt = 0, fd_cnt = 0, exp_hc = 0;
  bit noisy = 0;
  logic [SW-1:0] exp_ms = '0;

  always @(negedge clock) begin
    if (job_loaded) jl_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic noise();
    if (noisy) begin
      start = 1'($urandom);
      trace_done = 1'($urandom);
      trace_hit = 1'($urandom);
    end
  endtask

  task automatic quiet();
    start = 0;
    trace_done = 0;
  endtask

  task automatic begin_frame(input logic [SW-1:0] ms);
    cfg_max_steps = ms;
    start = 1;
    step();
    start = 0;
    cfg_max_steps = ~ms;
    exp_ms = ms;
    exp_hc = 0;
    #1;
    chk("start_busy", busy, 1);
    chk("start_max_steps", max_steps, ms);
    chk("start_hit_count", hit_count, 0);
  endtask

  task automatic go_wait(input pix_t p, input int x, input int y);
    #1;
    chk("setup_req", setup_req, 1);
    chk("setup_px", setup_px, x);
    chk("setup_py", setup_py, y);
    repeat (p.ack_d) begin noise(); step(); end
    quiet();
    setup_ack = 1;
    step();
    setup_ack = 0;
    #1 chk("issue_no_launch", job_loaded, 0);
    repeat (p.rdy_d) begin step(); #1 chk("stall_no_launch", job_loaded, 0); end
    trace_ready = 1;
    #1 chk("job_loaded", job_loaded, 1);
    step();
    trace_ready = 0;
  endtask

  task automatic go_output(input pix_t p, input int x, input int y);
    go_wait(p, x, y);
    repeat (p.lat - 1) step();
    trace_done = 1;
    trace_hit = p.hit;
    trace_timeout = p.to;
    trace_face = p.face;
    step();
    trace_done = 0;
    trace_hit = 1'($urandom);
    trace_timeout = 1'($urandom);
    trace_face = 3'($urandom);
  endtask

  task automatic pixel(input pix_t p, input int x, input int y);
    int jb;
    jb = jl_cnt;
    go_output(p, x, y);
    #1;
    chk("res_valid", res_valid, 1);
    chk("res_fields", {res_px, res_py, res_hit, res_timeout, res_face}, {3'(x), 3'(y), p.hit, p.to, p.face});
    repeat (p.rr_d) begin
      noise();
      step();
      #1;
      chk("bp_valid_no_setup", {res_valid, setup_req}, 2'b10);
      chk("bp_fields", {res_px, res_py, res_hit, res_timeout, res_face}, {3'(x), 3'(y), p.hit, p.to, p.face});
    end
    quiet();
    res_ready = 1;
    step();
    res_ready = 0;
    if (p.hit && exp_hc < (1 << CB) - 1) exp_hc++;
    #1;
    chk("hit_count", hit_count, exp_hc);
    chk("launches_per_pixel", jl_cnt - jb, 1);
  endtask

  task automatic end_frame();
    int fb;
    fb = fd_cnt;
    #1;
    chk("frame_done_pulse", {frame_done, busy}, 2'b10);
    chk("frame_hits", hit_count, exp_hc);
    chk("frame_max_steps", max_steps, exp_ms);
    step();
    #1;
    chk("frame_done_clear", {frame_done, busy}, 2'b00);
    chk("hit_count_hold", hit_count, exp_hc);
    chk("frame_done_once", fd_cnt - fb, 1);
  endtask

  vec_t tbl[8];
  int tbl_hits[2];

  initial begin
    pix_t p, q;
    int fb;
    tbl[0] = '{'{0, 0, 3, 0, 1'b0, 1'b0, 3'b001}, 0, 0};
    tbl[1] = '{'{0, 0, 3, 0, 1'b0, 1'b0, 3'b010}, 1, 0};
    tbl[2] = '{'{0, 0, 3, 0, 1'b0, 1'b0, 3'b100}, 0, 1};
    tbl[3] = '{'{0, 0, 3, 0, 1'b0, 1'b0, 3'b001}, 1, 1};
    tbl[4] = '{'{0, 0, 3, 5, 1'b0, 1'b0, 3'b001}, 0, 0};
    tbl[5] = '{'{0, 4, 3, 0, 1'b1, 1'b0, 3'b010}, 1, 0};
    tbl[6] = '{'{2, 0, 4, 0, 1'b0, 1'b1, 3'b100}, 0, 1};
    tbl[7] = '{'{1, 1, 3, 2, 1'b0, 1'b0, 3'b001}, 1, 1};
    tbl_hits = '{0, 1};

    #1 reset_n = 0;
    step();
    step();
    #1 chk("reset_outputs", {busy, frame_done, hit_count, setup_req, setup_px, setup_py, job_loaded,
      max_steps, res_valid, res_px, res_py, res_hit, res_timeout, res_face}, 64'd0);
    reset_n = 1;
    step();

    for (int f = 0; f < 2; f++) begin
      begin_frame(8'(8'h30 + f));
      for (int i = 0; i < 4; i++) pixel(tbl[f*4+i].p, tbl[f*4+i].ex, tbl[f*4+i].ey);
      chk("table_hits", hit_count, tbl_hits[f]);
      end_frame();
    end

    noisy = 1;
    for (int f = 0; f < 6; f++) begin
      begin_frame(8'($urandom));
      for (int i = 0; i < H * V; i++) begin
        p.ack_d = $urandom_range(0, 3);
        p.rdy_d = $urandom_range(0, 3);
        p.lat = $urandom_range(3, 5);
        p.rr_d = $urandom_range(0, 3);
        p.hit = 1'($urandom);
        p.to = 1'($urandom);
        p.face = 3'(3'b001 << $urandom_range(0, 2));
        pixel(p, i % H, i / H);
      end
      end_frame();
    end
    noisy = 0;
    quiet();

    q = '{0, 0, 3, 0, 1'b1, 1'b0, 3'b001};
    fb = fd_cnt;
    begin_frame(8'h21);
    go_wait(q, 0, 0);
    abort = 1;
    step();
    abort = 0;
    repeat (2) begin
      #1 chk("drain_busy_no_valid", {busy, res_valid}, 2'b10);
      step();
    end
    trace_done = 1;
    step();
    trace_done = 0;
    #1 chk("drain_to_idle", {busy, res_valid, frame_done}, 3'b000);
    step();
    #1 chk("abort_no_frame_done", fd_cnt - fb, 0);

    begin_frame(8'h44);
    go_output(q, 0, 0);
    abort = 1;
    res_ready = 1;
    step();
    abort = 0;
    res_ready = 0;
    #1 chk("abort_output_idle", {busy, res_valid}, 2'b00);
    chk("abort_output_no_count", hit_count, 0);
    step();
    #1 chk("abort_output_no_done", frame_done, 0);

    begin_frame(8'h45);
    setup_ack = 1;
    abort = 1;
    step();
    setup_ack = 0;
    abort = 0;
    #1 chk("abort_setup_idle", busy, 0);

    begin_frame(8'h46);
    setup_ack = 1;
    step();
    setup_ack = 0;
    trace_ready = 1;
    abort = 1;
    step();
    trace_ready = 0;
    abort = 0;
    #1 chk("abort_issue_idle", busy, 0);

    cfg_max_steps = 8'h77;
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    #1 chk("start_abort_idle", {busy, setup_req}, 2'b00);
    chk("start_abort_max_steps", max_steps, 8'h46);

    begin_frame(8'h5a);
    pixel('{0, 0, 3, 0, 1'b1, 1'b0, 3'b010}, 0, 0);
    go_output('{0, 0, 3, 0, 1'b1, 1'b1, 3'b100}, 1, 0);
    #1 chk("pre_reset_valid", {res_valid, hit_count}, {1'b1, 3'd1});
    reset_n = 0;
    #1 chk("async_reset_outputs", {busy, frame_done, hit_count, setup_req, setup_px, setup_py, job_loaded,
      max_steps, res_valid, res_px, res_py, res_hit, res_timeout, res_face}, 64'd0);
    step();
    reset_n = 1;
    fb = fd_cnt;
    step();
    step();
    #1 chk("post_reset_idle", {busy, frame_done}, 2'b00);
    chk("reset_no_frame_done", fd_cnt - fb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ray_frame_scheduler.md
# ray_frame_scheduler

Frame-level sequencer that walks a screen of pixels in raster order and runs one DDA ray job per pixel. For each pixel it requests ray setup from the setup unit, launches the job into the step-control tracer, and waits for termination. It then captures hit/timeout/face and hands the result downstream over a valid/ready port. It sits between the host start/abort control and the per-ray tracer, so the tracer itself stays frame-agnostic.

## Interface
- `PX_BITS`, default 6: pixel x coordinate width.
- `PY_BITS`, default 6: pixel y coordinate width.
- `H_RES`, default 40: pixels per row, 1..2^PX_BITS.
- `V_RES`, default 30: rows per frame, 1..2^PY_BITS.
- `STEP_COUNT_WIDTH`, default 16: max-steps width; matches the tracer.
- `CNT_BITS`, default 11: width of the hit counter; must hold H_RES*V_RES.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `abort`  in  1  cancel the current frame.
- `cfg_max_steps`  in  STEP_COUNT_WIDTH  per-ray step limit; latched when a start is accepted.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last result of a frame is accepted.
- `hit_count`  out  CNT_BITS  number of hit results accepted in the current/last frame.
- `setup_req`  out  1  request ray setup for (`setup_px`, `setup_py`).
- `setup_px`  out  PX_BITS  current pixel x.
- `setup_py`  out  PY_BITS  current pixel y.
- `setup_ack`  in  1  setup unit has driven the tracer's job parameters; they are stable until the next `setup_req`.
- `trace_ready`  in  1  tracer is idle.
- `job_loaded`  out  1  launch pulse to the tracer.
- `max_steps`  out  STEP_COUNT_WIDTH  latched `cfg_max_steps`.
- `trace_done`  in  1  tracer termination, one-cycle pulse.
- `trace_hit`  in  1  tracer hit flag; sampled when `trace_done` is high.
- `trace_timeout`  in  1  tracer timeout flag; sampled when `trace_done` is high.
- `trace_face`  in  3  one-hot entry face ([2]=Z, [1]=Y, [0]=X); sampled when `trace_done` is high.
- `res_valid`  out  1  result is available.
- `res_ready`  in  1  downstream accepts the result.
- `res_px`  out  PX_BITS  result pixel x.
- `res_py`  out  PY_BITS  result pixel y.
- `res_hit`  out  1  result hit flag.
- `res_timeout`  out  1  result timeout flag.
- `res_face`  out  3  result entry face.

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, OUTPUT, DRAIN.
- **IDLE:**
  - On `start` && !`abort`: px/py ← 0, `hit_count` ← 0, `max_steps` ← `cfg_max_steps`; go to SETUP.
  - `start` in any other state is ignored.
- **SETUP:**
  - `setup_req` = 1.
  - When `setup_ack` is high at a clock edge, go to ISSUE.
- **ISSUE:**
  - `job_loaded` = `trace_ready` (combinational, only in this state).
  - When `trace_ready` is high at an edge, go to WAIT.
- **WAIT:**
  - On `trace_done`: register `res_hit`/`res_timeout`/`res_face` from the `trace_*` inputs and `res_px`/`res_py` from the pixel counters; go to OUTPUT.
- **OUTPUT:**
  - `res_valid` = 1; all `res_*` fields are held stable while `res_ready` is low.
  - On `res_ready`: if `res_hit`, increment `hit_count`.
  - If (px,py) == (H_RES-1, V_RES-1): pulse `frame_done` next cycle and go to IDLE.
  - Otherwise advance the pixel (px+1; at px == H_RES-1, px ← 0 and py+1) and go to SETUP.
- **abort:**
  - In SETUP, ISSUE or OUTPUT: go to IDLE next edge. A pending result is dropped and `frame_done` is not pulsed.
  - In WAIT: go to DRAIN. The tracer cannot be cancelled.
  - Abort has priority over a simultaneous `setup_ack`, `trace_ready` or `res_ready`.
- **DRAIN:** wait for `trace_done`, discard the result, go to IDLE.
- `abort` in IDLE or DRAIN has no effect.
- Pixel counters never exceed H_RES-1 / V_RES-1. A 1x1 frame produces exactly one job.
- `hit_count` saturates at all-ones. It holds after the frame until the next accepted start.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE; every output is 0, including `max_steps`, `hit_count` and all `res_*` fields.
- Reset mid-frame abandons the frame immediately; no `frame_done` is produced.
- `start` accepted at edge k: `busy` and `setup_req` are high from k (after the edge).
- Best-case per-pixel overhead in the scheduler:
  - 1 cycle SETUP, when `setup_ack` is high in the first cycle;
  - 1 cycle ISSUE;
  - tracer latency (≥3 cycles: INIT, RUNNING, FINISH);
  - 1 cycle OUTPUT.
- `job_loaded` is high for exactly one cycle per pixel.
- `frame_done` is registered: high the cycle after the final OUTPUT handshake, concurrent with IDLE and `busy` = 0.
- A `trace_done` arriving outside WAIT/DRAIN is ignored.

## Test plan
- **2x2 frame, all misses:** H_RES=V_RES=2, instant ack/ready/`res_ready`, tracer done 3 cycles after launch → results for (0,0),(1,0),(0,1),(1,1) in order, 4 `job_loaded` pulses, `frame_done` once, `hit_count`=0.
- **Hit on one pixel:** `trace_hit`=1, `trace_face`=3'b010 on pixel (1,0) → that result carries hit=1, face=010; `hit_count`=1 at `frame_done`.
- **Backpressure:** `res_ready` low for 5 cycles on the first result → `res_valid` stays high with fields unchanged; no `setup_req` until accepted.
- **Launch stall:** `trace_ready` low for 4 cycles in ISSUE → `job_loaded` stays 0 during the stall, then pulses exactly once.
- **Abort in WAIT:** abort then `trace_done` 2 cycles later → DRAIN, no `res_valid`, IDLE next; `frame_done` never pulses.
- **Start rules:** `start` during a frame is ignored, and `cfg_max_steps` changed mid-frame leaves `max_steps` unchanged. `start` and `abort` together in IDLE → stays IDLE. `reset_n` asserted during OUTPUT → all outputs 0 asynchronously.
